// File: rtl/ram_sp_bus_ctrl_if.sv
// rtl/ram_sp_bus_ctrl_if.sv - request/response handshake bundle between a requester and ram_sp_bus_ctrl
interface ram_sp_bus_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_sp_bus_ctrl.sv
// rtl/ram_sp_bus_ctrl.sv - sequences control pins and shared data bus of a single-port RAM
// One request in flight; read data is returned on a held response channel.
module ram_sp_bus_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  ram_sp_bus_ctrl_if.slave   req_rsp,
  output logic               busy,
  output logic               ram_cs,
  output logic               ram_wr_en,
  output logic               ram_o_en,
  output logic [ADDR_W-1:0]  ram_rd_adrs,
  output logic [ADDR_W-1:0]  ram_wr_adrs,
  inout  wire  [DATA_W-1:0]  ram_data,
  output logic [COUNT_W-1:0] rd_count,
  output logic [COUNT_W-1:0] wr_count
);
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_DRIVE = 3'd3,
    S_RESP     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  rd_adrs_q, wr_adrs_q;
  logic [DATA_W-1:0]  wdata_q, rsp_data_q;
  logic [COUNT_W-1:0] rd_count_q, wr_count_q;
  logic               accept;
  logic               bus_drive;

  assign accept = (state_q == S_IDLE) && req_rsp.req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept) state_d = req_rsp.req_write ? S_WRITE : S_RD_ISSUE;
      S_WRITE:    state_d = S_IDLE;
      S_RD_ISSUE: state_d = S_RD_DRIVE;
      S_RD_DRIVE: state_d = S_RESP;
      S_RESP:     if (req_rsp.rsp_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // RAM pins and bus enable decode from the state register only, never from req_*.
  always_comb begin
    ram_cs            = (state_q == S_WRITE) || (state_q == S_RD_ISSUE) || (state_q == S_RD_DRIVE);
    ram_wr_en         = (state_q == S_WRITE);
    ram_o_en          = (state_q == S_RD_DRIVE);
    bus_drive         = (state_q == S_WRITE);
    busy              = (state_q != S_IDLE);
    req_rsp.req_ready = (state_q == S_IDLE) && !rst;
    req_rsp.rsp_valid = (state_q == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_adrs_q  <= '0;
      wr_adrs_q  <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (accept) begin
        if (req_rsp.req_write) begin
          wr_adrs_q <= req_rsp.req_addr;
          wdata_q   <= req_rsp.req_wdata;
        end else begin
          rd_adrs_q <= req_rsp.req_addr;
        end
      end
      if ((state_q == S_WRITE) && (wr_count_q != '1)) begin
        wr_count_q <= wr_count_q + COUNT_W'(1);
      end
      if (state_q == S_RD_DRIVE) begin
        rsp_data_q <= ram_data;
        if (rd_count_q != '1) begin
          rd_count_q <= rd_count_q + COUNT_W'(1);
        end
      end
    end
  end

  assign ram_data         = bus_drive ? wdata_q : {DATA_W{1'bz}};
  assign ram_rd_adrs      = rd_adrs_q;
  assign ram_wr_adrs      = wr_adrs_q;
  assign req_rsp.rsp_data = rsp_data_q;
  assign rd_count         = rd_count_q;
  assign wr_count         = wr_count_q;
endmodule
